// File: rtl/nf10_pkt_pkg.sv
// nf10_pkt_pkg: shared widths, TUSER field offsets and framer state codes
package nf10_pkt_pkg;
  localparam int DATA_W = 256;
  localparam int STRB_W = DATA_W / 8;
  localparam int TUSER_W = 128;
  localparam int LEN_OFF = 0;
  localparam int SRC_PORT_OFF = 16;
  localparam int DST_PORT_OFF = 24;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WORD1 = 3'd1;
  localparam logic [2:0] ST_WORD2 = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: single AXIS output register that holds its beat while stalled
module axis_reg_slice #(
  parameter int DW = 256,
  parameter int UW = 128
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  input  logic [DW/8-1:0] in_strb,
  input  logic [UW-1:0]   in_user,
  input  logic            in_last,
  output logic            load,
  output logic [DW-1:0]   m_tdata,
  output logic [DW/8-1:0] m_tstrb,
  output logic [UW-1:0]   m_tuser,
  output logic            m_tvalid,
  output logic            m_tlast,
  input  logic            m_tready
);
  logic            valid_q, valid_d, last_q, last_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW/8-1:0] strb_q, strb_d;
  logic [UW-1:0]   user_q, user_d;
  logic            take;
  assign load = !valid_q || m_tready;
  assign take = load && in_valid;
  always_comb begin
    valid_d = load ? in_valid : valid_q;
    data_d  = take ? in_data : data_q;
    strb_d  = take ? in_strb : strb_q;
    user_d  = take ? in_user : user_q;
    last_d  = take ? in_last : last_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
      user_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      user_q  <= user_d;
      last_q  <= last_d;
    end
  end
  assign m_tvalid = valid_q;
  assign m_tdata  = data_q;
  assign m_tstrb  = strb_q;
  assign m_tuser  = user_q;
  assign m_tlast  = last_q;
endmodule

// File: rtl/pkt_tx_framer.sv
// pkt_tx_framer: emits word1, word2 and an optional payload as one AXIS frame
module pkt_tx_framer
  import nf10_pkt_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH = DATA_W,
  parameter int C_M_AXIS_TUSER_WIDTH = TUSER_W,
  parameter logic [7:0] C_SRC_PORT = 8'h02
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               i_req_valid,
  output logic                               o_req_ready,
  input  logic [C_M_AXIS_DATA_WIDTH-1:0]     i_hdr_word1,
  input  logic [C_M_AXIS_DATA_WIDTH-1:0]     i_hdr_word2,
  input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]   i_word2_strb,
  input  logic                               i_has_payload,
  input  logic [C_M_AXIS_TUSER_WIDTH-1:0]    i_tuser,
  input  logic [C_M_AXIS_DATA_WIDTH-1:0]     s_pay_tdata,
  input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]   s_pay_tstrb,
  input  logic                               s_pay_tvalid,
  input  logic                               s_pay_tlast,
  output logic                               s_pay_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic                               m_axis_tvalid,
  output logic                               m_axis_tlast,
  input  logic                               m_axis_tready,
  output logic [31:0]                        o_pkt_count
);
  localparam int DW = C_M_AXIS_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int UW = C_M_AXIS_TUSER_WIDTH;
  logic [2:0]    state_q, state_d;
  logic [DW-1:0] word1_q, word1_d, word2_q, word2_d;
  logic [SW-1:0] strb_q, strb_d;
  logic          has_pay_q, has_pay_d;
  logic [UW-1:0] tuser_q, tuser_d, tuser_w1;
  logic [31:0]   cnt_q, cnt_d;
  logic          load, req_fire, pay_fire, out_fire;
  logic          in_valid, in_last;
  logic [DW-1:0] in_data;
  logic [SW-1:0] in_strb;
  logic [UW-1:0] in_user;
  // resetn gating keeps ready low while reset is held, even though the slice is empty
  assign o_req_ready  = resetn && state_q == ST_IDLE && load;
  assign s_pay_tready = state_q == ST_DATA && load;
  assign req_fire     = i_req_valid && o_req_ready;
  assign pay_fire     = s_pay_tvalid && s_pay_tready;
  assign out_fire     = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign o_pkt_count  = cnt_q;
  always_comb begin
    state_d   = state_q;
    word1_d   = word1_q;
    word2_d   = word2_q;
    strb_d    = strb_q;
    has_pay_d = has_pay_q;
    tuser_d   = tuser_q;
    cnt_d     = cnt_q;
    in_valid  = 1'b0;
    in_data   = word1_q;
    in_strb   = '1;
    in_user   = '0;
    in_last   = 1'b0;
    tuser_w1  = tuser_q;
    tuser_w1[SRC_PORT_OFF +: 8] = C_SRC_PORT;
    case (state_q)
      ST_IDLE: if (req_fire) begin
        word1_d   = i_hdr_word1;
        word2_d   = i_hdr_word2;
        strb_d    = i_word2_strb;
        has_pay_d = i_has_payload;
        tuser_d   = i_tuser;
        state_d   = ST_WORD1;
      end
      ST_WORD1: begin
        in_valid = 1'b1;
        in_user  = tuser_w1;
        state_d  = load ? ST_WORD2 : ST_WORD1;
      end
      ST_WORD2: begin
        in_valid = 1'b1;
        in_data  = word2_q;
        in_strb  = has_pay_q ? '1 : strb_q;
        in_last  = !has_pay_q;
        state_d  = !load ? ST_WORD2 : has_pay_q ? ST_DATA : ST_DONE;
      end
      ST_DATA: begin
        in_valid = s_pay_tvalid;
        in_data  = s_pay_tdata;
        in_strb  = s_pay_tstrb;
        in_last  = s_pay_tlast;
        state_d  = (pay_fire && s_pay_tlast) ? ST_DONE : ST_DATA;
      end
      ST_DONE: if (out_fire) begin
        cnt_d   = cnt_q + 32'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      word1_q   <= '0;
      word2_q   <= '0;
      strb_q    <= '0;
      has_pay_q <= 1'b0;
      tuser_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      word1_q   <= word1_d;
      word2_q   <= word2_d;
      strb_q    <= strb_d;
      has_pay_q <= has_pay_d;
      tuser_q   <= tuser_d;
      cnt_q     <= cnt_d;
    end
  end
  axis_reg_slice #(.DW(DW), .UW(UW)) u_slice (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_strb  (in_strb),
    .in_user  (in_user),
    .in_last  (in_last),
    .load     (load),
    .m_tdata  (m_axis_tdata),
    .m_tstrb  (m_axis_tstrb),
    .m_tuser  (m_axis_tuser),
    .m_tvalid (m_axis_tvalid),
    .m_tlast  (m_axis_tlast),
    .m_tready (m_axis_tready)
  );
endmodule

// File: tb/tb_pkt_tx_framer.sv
// tb_pkt_tx_framer: directed frames with hand-computed beats, stalls, gaps and reset
module tb_pkt_tx_framer;
  localparam int DW = 256;
  localparam int SW = 32;
  localparam int UW = 128;
  localparam logic [DW-1:0] W1 = {8{32'hA1A1_0001}};
  localparam logic [DW-1:0] W2 = {8{32'hB2B2_0002}};
  localparam logic [DW-1:0] PA = {8{32'hCAFE_000A}};
  localparam logic [DW-1:0] PB = {8{32'hCAFE_000B}};
  localparam logic [DW-1:0] PC = {8{32'hCAFE_000C}};
  localparam logic [SW-1:0] ONES = 32'hFFFF_FFFF;
  localparam logic [UW-1:0] TU_IN  = {32'hDEAD_BEEF, 64'h0, 32'h0455_003C};
  localparam logic [UW-1:0] TU_EXP = {32'hDEAD_BEEF, 64'h0, 32'h0402_003C};

  logic clk = 1'b0, resetn = 1'b0;
  logic i_req_valid = 1'b0, o_req_ready;
  logic [DW-1:0] i_hdr_word1 = '0, i_hdr_word2 = '0;
  logic [SW-1:0] i_word2_strb = '0;
  logic i_has_payload = 1'b0;
  logic [UW-1:0] i_tuser = '0;
  logic [DW-1:0] s_pay_tdata = '0;
  logic [SW-1:0] s_pay_tstrb = '0;
  logic s_pay_tvalid = 1'b0, s_pay_tlast = 1'b0, s_pay_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [SW-1:0] m_axis_tstrb;
  logic [UW-1:0] m_axis_tuser;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b0;
  logic [31:0] o_pkt_count;

  always #5 clk = ~clk;

  pkt_tx_framer dut (
    .clk(clk), .resetn(resetn),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_hdr_word1(i_hdr_word1), .i_hdr_word2(i_hdr_word2),
    .i_word2_strb(i_word2_strb), .i_has_payload(i_has_payload), .i_tuser(i_tuser),
    .s_pay_tdata(s_pay_tdata), .s_pay_tstrb(s_pay_tstrb), .s_pay_tvalid(s_pay_tvalid),
    .s_pay_tlast(s_pay_tlast), .s_pay_tready(s_pay_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .o_pkt_count(o_pkt_count)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic last;
    int cyc;
  } beat_t;

  beat_t beats[$];
  int acc[$];
  int cyc = 0, n_last = 0, stall_err = 0, stall_cnt = 0;
  int n_vec = 0, n_err = 0;
  logic prev_stall = 1'b0, p_last = 1'b0;
  logic [DW-1:0] p_data = '0;
  bit bp_on = 1'b0;

  // inputs change just after posedge, so the negedge sees what the next edge will use
  always @(negedge clk) begin
    if (!resetn) prev_stall = 1'b0;
    else begin
      if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== p_data || m_axis_tlast !== p_last))
        stall_err++;
      if (m_axis_tvalid && m_axis_tready) begin
        beats.push_back('{m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast, cyc});
        if (m_axis_tlast) n_last++;
      end
      if (i_req_valid && o_req_ready) acc.push_back(cyc);
      prev_stall = m_axis_tvalid && !m_axis_tready;
      if (prev_stall) stall_cnt++;
      p_data = m_axis_tdata;
      p_last = m_axis_tlast;
    end
    cyc++;
  end

  task automatic set_req(input logic hp, input logic [SW-1:0] st);
    i_hdr_word1 = W1; i_hdr_word2 = W2; i_word2_strb = st; i_has_payload = hp; i_tuser = TU_IN;
  endtask

  task automatic send_req(input logic hp, input logic [SW-1:0] st);
    bit ok;
    ok = 1'b0;
    set_req(hp, st);
    i_req_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (o_req_ready) ok = 1'b1;
    end
    @(posedge clk); #1 i_req_valid = 1'b0;
    if (!ok) begin n_vec++; n_err++; $display("FAIL req_accept_timeout: accepted=0 required=1"); end
  endtask

  task automatic drive_payload(input int gap);
    logic [DW-1:0] d[3];
    logic [SW-1:0] s[3];
    bit ok;
    d = '{PA, PB, PC};
    s = '{ONES, ONES, 32'h0000_00FF};
    for (int k = 0; k < 3; k++) begin
      ok = 1'b0;
      s_pay_tdata = d[k]; s_pay_tstrb = s[k]; s_pay_tlast = (k == 2); s_pay_tvalid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
        @(negedge clk);
        if (s_pay_tready) ok = 1'b1;
      end
      @(posedge clk); #1 s_pay_tvalid = 1'b0;
      if (!ok) begin n_vec++; n_err++; $display("FAIL pay_beat_timeout: beat=%0d accepted=0 required=1", k); end
      if (k == 0 && gap > 0) begin repeat (gap) @(posedge clk); #1; end
    end
  endtask

  task automatic wait_frame(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk); #2;
      if (n_last >= target) ok = 1'b1;
    end
    if (!ok) begin n_vec++; n_err++; $display("FAIL frame_timeout: tlast_seen=%0d required=%0d", n_last, target); end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got=%b exp=0", m_axis_tvalid); end
    n_vec++; if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast: got=%b exp=0", m_axis_tlast); end
    n_vec++; if (m_axis_tdata !== '0) begin n_err++; $display("FAIL rst_tdata: got=%0h exp=0", m_axis_tdata); end
    n_vec++; if (m_axis_tuser !== '0 || m_axis_tstrb !== '0) begin n_err++; $display("FAIL rst_tuser_tstrb: got=%0h/%0h exp=0/0", m_axis_tuser, m_axis_tstrb); end
    n_vec++; if (o_req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got=%b exp=0", o_req_ready); end
    n_vec++; if (s_pay_tready !== 1'b0) begin n_err++; $display("FAIL rst_pay_tready: got=%b exp=0", s_pay_tready); end
    n_vec++; if (o_pkt_count !== 32'd0) begin n_err++; $display("FAIL rst_count: got=%0d exp=0", o_pkt_count); end
    resetn = 1'b1;
    m_axis_tready = 1'b1;
    #1;
    n_vec++; if (o_req_ready !== 1'b1) begin n_err++; $display("FAIL idle_req_ready: got=%b exp=1", o_req_ready); end
  endtask

  task automatic test_no_payload;
    int t;
    beats.delete(); acc.delete();
    t = n_last + 1;
    send_req(1'b0, 32'h0000_FFFF);
    wait_frame(t);
    n_vec++; if (beats.size() != 2) begin n_err++; $display("FAIL np_beats: got=%0d exp=2", beats.size()); end
    if (beats.size() >= 2) begin
      n_vec++; if (beats[0].data !== W1 || beats[0].strb !== ONES || beats[0].last !== 1'b0) begin n_err++; $display("FAIL np_beat0: data=%0h strb=%0h last=%b", beats[0].data, beats[0].strb, beats[0].last); end
      n_vec++; if (beats[0].user !== TU_EXP) begin n_err++; $display("FAIL np_tuser0: got=%0h exp=%0h", beats[0].user, TU_EXP); end
      n_vec++; if (beats[1].data !== W2 || beats[1].last !== 1'b1 || beats[1].user !== '0) begin n_err++; $display("FAIL np_beat1: data=%0h last=%b user=%0h", beats[1].data, beats[1].last, beats[1].user); end
      n_vec++; if (beats[1].strb !== 32'h0000_FFFF) begin n_err++; $display("FAIL np_strb1: got=%0h exp=0000ffff", beats[1].strb); end
      n_vec++; if (beats[1].cyc - beats[0].cyc != 1) begin n_err++; $display("FAIL np_spacing: got=%0d exp=1", beats[1].cyc - beats[0].cyc); end
    end
    if (acc.size() >= 1 && beats.size() >= 1) begin
      n_vec++; if (beats[0].cyc - acc[0] != 2) begin n_err++; $display("FAIL np_latency: got=%0d exp=2", beats[0].cyc - acc[0]); end
    end
    n_vec++; if (o_pkt_count !== 32'd1) begin n_err++; $display("FAIL np_count: got=%0d exp=1", o_pkt_count); end
  endtask

  task automatic test_payload;
    int t;
    logic [DW-1:0] ed[5];
    logic [SW-1:0] es[5];
    beats.delete();
    ed = '{W1, W2, PA, PB, PC};
    es = '{ONES, ONES, ONES, ONES, 32'h0000_00FF};
    t = n_last + 1;
    fork
      send_req(1'b1, 32'h0000_0001);
      drive_payload(0);
    join
    wait_frame(t);
    n_vec++; if (beats.size() != 5) begin n_err++; $display("FAIL pl_beats: got=%0d exp=5", beats.size()); end
    for (int k = 0; k < 5 && k < beats.size(); k++) begin
      n_vec++;
      if (beats[k].data !== ed[k] || beats[k].strb !== es[k] || beats[k].last !== (k == 4) ||
          beats[k].user !== (k == 0 ? TU_EXP : '0)) begin
        n_err++; $display("FAIL pl_beat%0d: data=%0h strb=%0h last=%b user=%0h", k, beats[k].data, beats[k].strb, beats[k].last, beats[k].user);
      end
    end
    if (beats.size() == 5) begin
      n_vec++; if (beats[4].cyc - beats[0].cyc != 4) begin n_err++; $display("FAIL pl_throughput: got=%0d exp=4", beats[4].cyc - beats[0].cyc); end
    end
    n_vec++; if (o_pkt_count !== 32'd2) begin n_err++; $display("FAIL pl_count: got=%0d exp=2", o_pkt_count); end
  endtask

  task automatic test_backpressure;
    int t;
    logic [DW-1:0] ed[5];
    beats.delete();
    ed = '{W1, W2, PA, PB, PC};
    stall_err = 0; stall_cnt = 0;
    t = n_last + 1;
    bp_on = 1'b1;
    fork
      begin
        fork
          send_req(1'b1, 32'h0000_0001);
          drive_payload(0);
        join
        wait_frame(t);
        bp_on = 1'b0;
      end
      begin
        int k;
        k = 0;
        while (bp_on) begin
          m_axis_tready = (k % 4 == 0) || (k % 4 == 3);
          k++;
          @(posedge clk); #1;
        end
      end
    join
    m_axis_tready = 1'b1;
    n_vec++; if (beats.size() != 5) begin n_err++; $display("FAIL bp_beats: got=%0d exp=5", beats.size()); end
    for (int k = 0; k < 5 && k < beats.size(); k++) begin
      n_vec++;
      if (beats[k].data !== ed[k] || beats[k].last !== (k == 4)) begin
        n_err++; $display("FAIL bp_beat%0d: data=%0h last=%b", k, beats[k].data, beats[k].last);
      end
    end
    n_vec++; if (stall_cnt == 0) begin n_err++; $display("FAIL bp_stalls_seen: got=0 exp>0"); end
    n_vec++; if (stall_err != 0) begin n_err++; $display("FAIL bp_hold_stable: violations=%0d exp=0", stall_err); end
    n_vec++; if (o_pkt_count !== 32'd3) begin n_err++; $display("FAIL bp_count: got=%0d exp=3", o_pkt_count); end
  endtask

  task automatic test_gaps;
    int t;
    logic [DW-1:0] ed[5];
    beats.delete();
    ed = '{W1, W2, PA, PB, PC};
    t = n_last + 1;
    fork
      send_req(1'b1, 32'h0000_0001);
      drive_payload(3);
    join
    wait_frame(t);
    n_vec++; if (beats.size() != 5) begin n_err++; $display("FAIL gap_beats: got=%0d exp=5", beats.size()); end
    for (int k = 0; k < 5 && k < beats.size(); k++) begin
      n_vec++;
      if (beats[k].data !== ed[k] || beats[k].last !== (k == 4)) begin
        n_err++; $display("FAIL gap_beat%0d: data=%0h last=%b", k, beats[k].data, beats[k].last);
      end
    end
    if (beats.size() == 5) begin
      n_vec++; if (beats[3].cyc - beats[2].cyc != 4) begin n_err++; $display("FAIL gap_bubbles: got=%0d exp=4", beats[3].cyc - beats[2].cyc); end
    end
    n_vec++; if (o_pkt_count !== 32'd4) begin n_err++; $display("FAIL gap_count: got=%0d exp=4", o_pkt_count); end
  endtask

  task automatic test_back_to_back;
    int t;
    beats.delete(); acc.delete();
    t = n_last + 2;
    set_req(1'b0, 32'h0000_FFFF);
    i_req_valid = 1'b1;
    wait_frame(t);
    i_req_valid = 1'b0;
    n_vec++; if (acc.size() != 2) begin n_err++; $display("FAIL b2b_accepts: got=%0d exp=2", acc.size()); end
    n_vec++; if (beats.size() != 4) begin n_err++; $display("FAIL b2b_beats: got=%0d exp=4", beats.size()); end
    if (beats.size() == 4) begin
      n_vec++; if (beats[1].last !== 1'b1 || beats[3].last !== 1'b1 || beats[2].data !== W1) begin n_err++; $display("FAIL b2b_framing: last1=%b last3=%b data2=%0h", beats[1].last, beats[3].last, beats[2].data); end
      n_vec++; if (beats[2].cyc - beats[1].cyc != 3) begin n_err++; $display("FAIL b2b_idle_gap: got=%0d exp=3", beats[2].cyc - beats[1].cyc); end
      if (acc.size() == 2) begin
        n_vec++; if (acc[1] - beats[1].cyc != 1) begin n_err++; $display("FAIL b2b_second_accept: got=%0d exp=1", acc[1] - beats[1].cyc); end
      end
    end
    n_vec++; if (o_pkt_count !== 32'd6) begin n_err++; $display("FAIL b2b_count: got=%0d exp=6", o_pkt_count); end
  endtask

  task automatic test_async_reset;
    int t;
    bit ok;
    m_axis_tready = 1'b1;
    fork
      send_req(1'b1, 32'h0000_0001);
      begin
        s_pay_tdata = PA; s_pay_tstrb = ONES; s_pay_tlast = 1'b0; s_pay_tvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); if (s_pay_tready) ok = 1'b1; end
        @(posedge clk); #1 s_pay_tdata = PB;
        for (int i = 0; i < 200 && ok; i++) begin @(negedge clk); if (s_pay_tready) i = 200; end
        @(posedge clk); #1;
        if (!ok) begin n_vec++; n_err++; $display("FAIL ar_pay_timeout: accepted=0 required=1"); end
      end
    join
    n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== PB) begin n_err++; $display("FAIL ar_beat_b_loaded: valid=%b data=%0h exp=1/%0h", m_axis_tvalid, m_axis_tdata, PB); end
    resetn = 1'b0;
    s_pay_tvalid = 1'b0;
    #1;
    n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL ar_tvalid: got=%b exp=0", m_axis_tvalid); end
    n_vec++; if (m_axis_tdata !== '0) begin n_err++; $display("FAIL ar_tdata: got=%0h exp=0", m_axis_tdata); end
    n_vec++; if (o_pkt_count !== 32'd0) begin n_err++; $display("FAIL ar_count: got=%0d exp=0", o_pkt_count); end
    n_vec++; if (s_pay_tready !== 1'b0 || o_req_ready !== 1'b0) begin n_err++; $display("FAIL ar_readies: pay=%b req=%b exp=0/0", s_pay_tready, o_req_ready); end
    @(posedge clk); #1 resetn = 1'b1;
    #1;
    n_vec++; if (o_req_ready !== 1'b1) begin n_err++; $display("FAIL ar_idle: req_ready=%b exp=1", o_req_ready); end
    beats.delete();
    t = n_last + 1;
    send_req(1'b0, 32'h0000_FFFF);
    wait_frame(t);
    n_vec++; if (beats.size() != 2) begin n_err++; $display("FAIL ar_clean_beats: got=%0d exp=2", beats.size()); end
    if (beats.size() == 2) begin
      n_vec++; if (beats[0].data !== W1 || beats[0].user !== TU_EXP || beats[1].data !== W2 || beats[1].last !== 1'b1 || beats[1].strb !== 32'h0000_FFFF) begin
        n_err++; $display("FAIL ar_clean_frame: d0=%0h u0=%0h d1=%0h last1=%b s1=%0h", beats[0].data, beats[0].user, beats[1].data, beats[1].last, beats[1].strb);
      end
    end
    n_vec++; if (o_pkt_count !== 32'd1) begin n_err++; $display("FAIL ar_clean_count: got=%0d exp=1", o_pkt_count); end
  endtask

  initial begin
    test_reset();
    test_no_payload();
    test_payload();
    test_backpressure();
    test_gaps();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pkt_tx_framer.md
Name: pkt_tx_framer

Overview:
- AXI-Stream packet transmitter; the emitting counterpart of the receive-side word1/word2/data packet tracker in the router output-port-lookup path.
- Takes one header request (two 256-bit header words plus TUSER) and an optional payload stream.
- Emits one well-formed frame on the master AXIS: word1, word2, then payload beats, with TLAST on the final beat.
- Used for CPU-originated and locally generated packets (ARP replies, ICMP) ahead of the output queues.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, TDATA width; TSTRB width is /8.
- C_M_AXIS_TUSER_WIDTH, 128, TUSER width.
- C_SRC_PORT, 8'h02, one-hot source-port code forced into TUSER[23:16] on the first beat (odd bits = from CPU).

Ports:
- clk  in  1  single clock.
- resetn  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  header request valid.
- o_req_ready  out  1  request accepted this cycle when both are high.
- i_hdr_word1  in  256  Ethernet header plus first part of IPv4 header.
- i_hdr_word2  in  256  remainder of IPv4 header / options / upper-layer data.
- i_word2_strb  in  32  TSTRB of word2; used only when there is no payload.
- i_has_payload  in  1  1 = append the payload stream after word2.
- i_tuser  in  128  metadata; [15:0] byte length, [31:24] destination ports.
- s_pay_tdata  in  256  payload data.
- s_pay_tstrb  in  32  payload byte strobes.
- s_pay_tvalid  in  1  payload beat valid.
- s_pay_tlast  in  1  last payload beat.
- s_pay_tready  out  1  payload beat accepted.
- m_axis_tdata  out  256  output data.
- m_axis_tstrb  out  32  output byte strobes.
- m_axis_tuser  out  128  output metadata.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tlast  out  1  output last beat.
- m_axis_tready  in  1  downstream ready.
- o_pkt_count  out  32  frames fully emitted (TLAST beat accepted).

Behaviour:
- Reset (resetn low, asynchronous):
  - state = ST_IDLE.
  - All m_axis_* outputs, o_req_ready, s_pay_tready and o_pkt_count = 0.
  - Latched header registers are cleared.
- Output stage:
  - Single register slice; `load = !m_axis_tvalid || m_axis_tready`.
  - Data and control hold stable while tvalid=1 and tready=0 (AXIS rule).
  - A beat transfers when tvalid && tready.
- ST_IDLE:
  - o_req_ready = load.
  - On i_req_valid && o_req_ready: latch both header words, strb, has_payload and tuser; go to ST_WORD1.
- ST_WORD1: when load, present
  - tdata = word1, tstrb = all ones;
  - tuser = latched tuser with [23:16] replaced by C_SRC_PORT;
  - tlast = 0;
  - go to ST_WORD2.
- ST_WORD2: when load, present
  - tdata = word2, tuser = 0;
  - if !has_payload: tstrb = latched strb, tlast = 1, go to ST_DONE;
  - else: tstrb = all ones, tlast = 0, go to ST_DATA.
- ST_DATA:
  - s_pay_tready = load.
  - On each payload handshake, copy tdata/tstrb/tlast into the output register; tuser = 0.
  - On the payload tlast handshake, go to ST_DONE.
  - A payload tvalid gap yields m_axis_tvalid=0 bubbles, never a duplicated beat.
- ST_DONE:
  - Wait for the output tlast beat to be accepted.
  - o_pkt_count += 1 (wraps modulo 2^32); go to ST_IDLE.
  - o_req_ready is 0 in this state, so at most one frame is in flight.
- Latency and throughput:
  - Request accept to first m_axis_tvalid = 1 cycle.
  - With tready held high, one beat per cycle; back-to-back frames have exactly 2 idle cycles (DONE, IDLE) between TLAST and the next word1.
- s_pay_tready is 0 outside ST_DATA; payload presented early is simply held upstream.
- Minimum frame is 2 beats (the no-payload case).
- Reset mid-frame:
  - Output is dropped immediately (tvalid=0).
  - Any payload beats already partially consumed are not drained; upstream must be reset together with this block.
- Simultaneous events:
  - A request arriving during ST_DONE/ST_DATA is not accepted until ST_IDLE.
  - tready deasserting on the same cycle as a state advance stalls that advance.

Decomposition:
- Shared package nf10_pkt_pkg:
  - state encodings ST_IDLE/ST_WORD1/ST_WORD2/ST_DATA/ST_DONE;
  - TUSER field offsets LEN_OFF=0, SRC_PORT_OFF=16, DST_PORT_OFF=24;
  - widths.
- One natural sub-module, axis_reg_slice: the output register slice with the load/hold logic.
- The FSM and counter remain in pkt_tx_framer.

Test Plan:
- No-payload frame:
  - Stimulus: req, has_payload=0, strb=32'h0000_FFFF, tuser[15:0]=60, tready=1.
  - Required: 2 beats; beat0 tuser[23:16]=8'h02, tstrb=all ones; beat1 tlast=1, tstrb=32'h0000_FFFF; o_pkt_count=1.
- Payload frame:
  - Stimulus: 3 payload beats A,B,C with C tstrb=32'h0000_00FF, tlast.
  - Required: output order word1, word2, A, B, C; tlast only on C; tuser nonzero only on beat0.
- Backpressure:
  - Stimulus: toggle tready 1,0,0,1 every cycle across the frame.
  - Required: no beat lost or duplicated; tdata/tlast stable during every stall.
- Payload gaps:
  - Stimulus: s_pay_tvalid low 3 cycles between A and B.
  - Required: output shows bubbles only; beat sequence unchanged.
- Back-to-back requests:
  - Stimulus: i_req_valid held high for 2 frames.
  - Required: second request accepted only after the first TLAST handshake; exactly 2 idle cycles between frames; count=2.
- Async reset:
  - Stimulus: assert resetn=0 mid-payload beat B.
  - Required: m_axis_tvalid=0 the same cycle, count=0, state IDLE; the next request produces a clean frame.
